// File: rtl/fpu_addsub_arbiter_pkg.sv
// rtl/fpu_addsub_arbiter_pkg.sv - shared fp16 types, flags, FSM states and helpers
package fpu_addsub_arbiter_pkg;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] man;
  } fp16_t;

  // z: result is zero, c: mantissa carry-out (add) or operand swap/borrow (sub),
  // n: result sign, v: overflow to infinity
  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } condCode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arbState_t;

  localparam fp16_t FP16_QNAN = 16'h7E00;

  function automatic logic [3:0] lzc14(input logic [13:0] v);
    logic [3:0] n;
    n = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (v[i]) n = 4'(13 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fpu_addsub_arbiter_if.sv
// rtl/fpu_addsub_arbiter_if.sv - two-requester request/response bus of the shared adder
interface fpu_addsub_arbiter_if;
  import fpu_addsub_arbiter_pkg::*;

  logic [1:0]      reqValid;
  logic [1:0]      reqReady;
  logic [1:0]      reqSub;
  fp16_t [1:0]     reqA;
  fp16_t [1:0]     reqB;
  logic [1:0]      respValid;
  logic [1:0]      respReady;
  fp16_t           respResult;
  condCode_t       respCond;
  logic            busy;

  modport master (
    output reqValid, reqSub, reqA, reqB, respReady,
    input  reqReady, respValid, respResult, respCond, busy
  );

  modport slave (
    input  reqValid, reqSub, reqA, reqB, respReady,
    output reqReady, respValid, respResult, respCond, busy
  );
endinterface

// File: rtl/fpu_addsub_arbiter_addsub.sv
// rtl/fpu_addsub_arbiter_addsub.sv - combinational fp16 add/subtract, round-to-nearest-even
module fpuAddSub16
  import fpu_addsub_arbiter_pkg::*;
(
  input  fp16_t     a,
  input  fp16_t     b,
  input  logic      sub,
  output fp16_t     result,
  output condCode_t cond
);
  logic        bSign, effSub, swap, aNan, bNan, aInf, bInf, roundUp, ovf;
  logic [10:0] ma, mb, mL, mS;
  logic [4:0]  ea, eb, eL, eS, diff;
  logic        sL;
  logic [27:0] wide;
  logic [13:0] alignL, alignS, norm;
  logic [14:0] sum;
  logic [3:0]  lz;
  logic [5:0]  expN, expR;
  logic [11:0] mant;
  logic [9:0]  manR;

  always_comb begin
    bSign  = b.sign ^ sub;
    effSub = a.sign ^ bSign;
    aNan   = (a.exp == 5'd31) && (a.man != 10'd0);
    bNan   = (b.exp == 5'd31) && (b.man != 10'd0);
    aInf   = (a.exp == 5'd31) && (a.man == 10'd0);
    bInf   = (b.exp == 5'd31) && (b.man == 10'd0);
    ma     = {a.exp != 5'd0, a.man};
    mb     = {b.exp != 5'd0, b.man};
    ea     = (a.exp == 5'd0) ? 5'd1 : a.exp;
    eb     = (b.exp == 5'd0) ? 5'd1 : b.exp;
    swap   = {eb, mb} > {ea, ma};
    eL     = swap ? eb : ea;
    eS     = swap ? ea : eb;
    mL     = swap ? mb : ma;
    mS     = swap ? ma : mb;
    sL     = swap ? bSign : a.sign;
    diff   = eL - eS;
    // guard/round bits plus a sticky bit collecting everything shifted out
    wide   = {mS, 17'b0} >> diff;
    alignS = (diff >= 5'd28) ? {13'b0, |mS} : {wide[27:15], |wide[14:0]};
    alignL = {mL, 3'b000};
    sum    = effSub ? ({1'b0, alignL} - {1'b0, alignS})
                    : ({1'b0, alignL} + {1'b0, alignS});
    lz     = lzc14(sum[13:0]);
    if (sum[14]) begin
      norm = {sum[14:2], sum[1] | sum[0]};
      expN = 6'(eL) + 6'd1;
    end else if ({1'b0, lz} < eL) begin
      norm = sum[13:0] << lz;
      expN = 6'(eL) - 6'(lz);
    end else begin
      norm = sum[13:0] << (eL - 5'd1);
      expN = 6'd0;
    end
    roundUp = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant    = {1'b0, norm[13:3]} + 12'(roundUp);
    manR    = mant[9:0];
    if (mant[11])                       expR = expN + 6'd1;
    else if (expN == 6'd0 && mant[10])  expR = 6'd1;
    else                                expR = expN;
    ovf = expR >= 6'd31;

    cond.v = 1'b0;
    cond.c = 1'b0;
    if (aNan || bNan || (aInf && bInf && effSub)) begin
      result = FP16_QNAN;
    end else if (aInf) begin
      result = a;
    end else if (bInf) begin
      result = {bSign, 5'd31, 10'd0};
    end else if (sum == 15'd0) begin
      result = {effSub ? 1'b0 : a.sign, 15'd0};
    end else if (ovf) begin
      result = {sL, 5'd31, 10'd0};
      cond.v = 1'b1;
      cond.c = effSub ? swap : sum[14];
    end else begin
      result = {sL, expR[4:0], manR};
      cond.c = effSub ? swap : sum[14];
    end
    cond.z = (result.exp == 5'd0) && (result.man == 10'd0);
    cond.n = result.sign;
  end
endmodule

// File: rtl/fpu_addsub_arbiter_rr.sv
// rtl/fpu_addsub_arbiter_rr.sv - two-way round-robin grant
module fpu_rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       lastGrant,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = lastGrant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/fpu_addsub_arbiter.sv
// rtl/fpu_addsub_arbiter.sv - round-robin sharing of one fp16 adder between two requesters
module fpu_addsub_arbiter
  import fpu_addsub_arbiter_pkg::*;
(
  input logic                  clock,
  input logic                  reset,
  fpu_addsub_arbiter_if.slave  bus
);
  arbState_t state;
  logic      lastGrant;
  logic      owner;
  fp16_t     opA, opB;
  logic      opSub;
  fp16_t     fpuOut;
  condCode_t condCodes;
  logic [1:0] grant;
  logic [1:0] respValidQ;
  fp16_t     respResultQ;
  condCode_t respCondQ;

  fpu_rr_arbiter2 uArb (
    .valid     (bus.reqValid),
    .lastGrant (lastGrant),
    .grant     (grant)
  );

  fpuAddSub16 uFpu (
    .a      (opA),
    .b      (opB),
    .sub    (opSub),
    .result (fpuOut),
    .cond   (condCodes)
  );

  // reset is folded in so no grant is shown while reset is held
  assign bus.reqReady   = (state == IDLE && !reset) ? grant : 2'b00;
  assign bus.busy       = (state != IDLE);
  assign bus.respValid  = respValidQ;
  assign bus.respResult = respResultQ;
  assign bus.respCond   = respCondQ;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lastGrant   <= 1'b1;
      owner       <= 1'b0;
      opA         <= '0;
      opB         <= '0;
      opSub       <= 1'b0;
      respValidQ  <= 2'b00;
      respResultQ <= '0;
      respCondQ   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            owner     <= grant[1];
            opA       <= bus.reqA[grant[1]];
            opB       <= bus.reqB[grant[1]];
            opSub     <= bus.reqSub[grant[1]];
            lastGrant <= grant[1];
            state     <= EXEC;
          end
        end
        EXEC: begin
          respResultQ <= fpuOut;
          respCondQ   <= condCodes;
          respValidQ  <= owner ? 2'b10 : 2'b01;
          state       <= RESP;
        end
        RESP: begin
          if (bus.respReady[owner]) begin
            respValidQ <= 2'b00;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fpu_addsub_arbiter.md
FPU_ADDSUB_ARBITER -- requirements
Module: fpu_addsub_arbiter

Interface
REQ-001 SHALL expose `clock`, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL expose `reset`, input, 1, asynchronous active-high reset.
REQ-003 SHALL expose `reqValid`, input, [1:0], per-requester operation request.
REQ-004 SHALL expose `reqReady`, output, [1:0], per-requester accept; at most one bit set.
REQ-005 SHALL expose `reqSub`, input, [1:0], per-requester op select: 1=subtract, 0=add.
REQ-006 SHALL expose `reqA` and `reqB`, input, 2 x fp16_t, per-requester operands.
REQ-007 SHALL expose `respValid`, output, [1:0], per-requester result valid; at most one bit set.
REQ-008 SHALL expose `respReady`, input, [1:0], per-requester result consume.
REQ-009 SHALL expose `respResult`, output, fp16_t, the result, shared by both requesters.
REQ-010 SHALL expose `respCond`, output, condCode_t {Z,C,N,V}, the result flags, shared by both requesters.
REQ-011 SHALL expose `busy`, output, 1, high whenever state is not IDLE.

Function
REQ-012 SHALL share one fpuAddSub16 instance between two requesters; FSM states IDLE, EXEC, RESP.
REQ-013 In IDLE with any reqValid set, SHALL assert reqReady to exactly one granted requester in the same cycle.
- reqReady depends combinationally on reqValid and state only.
REQ-014 Grant SHALL be round-robin:
- one requester valid: it wins;
- both valid: the requester not granted last wins;
- last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-015 On handshake (reqValid[i] & reqReady[i]):
- SHALL latch the operands, reqSub[i] and owner index i;
- SHALL update the last-grant pointer;
- SHALL move to EXEC.
REQ-016 In EXEC, SHALL drive the adder from the latched registers, register fpuOut and condCodes into respResult/respCond, and move to RESP.
REQ-017 In RESP, SHALL hold respValid[owner]=1 and keep respResult/respCond stable until respReady[owner]=1, then return to IDLE.
- respReady of the non-owner SHALL be ignored.
REQ-018 Latency SHALL be: handshake at cycle t -> respValid at t+2. Minimum issue interval is 3 cycles.
REQ-019 reqReady SHALL be 0 in EXEC and RESP; requests pending there SHALL wait without loss.
- A request raised during RESP is arbitrated in the following IDLE cycle.
REQ-020 Operand changes after handshake SHALL NOT affect the in-flight result.
REQ-021 respResult/respCond SHALL retain their last value after a response is consumed.

Reset
REQ-022 On reset assertion, asynchronously and regardless of state:
- state=IDLE, last-grant pointer=1;
- reqReady=0 and respValid=0;
- respResult=0 and respCond=0;
- any in-flight operation is discarded.
REQ-023 After reset deassertion, the first cycle SHALL arbitrate normally.

Structure
REQ-024 fp16_t, condCode_t and a state enum SHALL live in the shared constants/lib package; no local redefinitions.
REQ-025 SHALL instantiate exactly one fpuAddSub16 sub-module; the round-robin grant logic may live in a sub-module fpu_rr_arbiter2.

Verification
REQ-026 Single add: req0 A=0x3C00 (1.0), B=0x4000 (2.0), sub=0 -> respValid[0] at t+2, result 0x4200, cond Z=0 N=0.
REQ-027 Subtract to zero: req1 A=0x4200, B=0x4200, sub=1 -> respValid[1], result 0x0000, Z=1.
REQ-028 Contention: both valid at the first cycle after reset -> grant order 0,1,0,1, each result to the correct owner; the second result is 0x4000 for req1 3.0-1.0.
REQ-029 Backpressure: hold respReady[0]=0 for 5 cycles -> respValid[0] and result stay stable, reqReady=00 throughout, req1 is served afterwards.
REQ-030 Reset mid-EXEC -> next cycle shows state IDLE, respValid=00, respResult=0; a fresh request completes correctly.
REQ-031 Wrong-owner consume: respReady[1]=1 while owner=0 -> no state change.
